// File: rtl/booth_sequencer.sv
// Radix-2 Booth multiplier: one partial-product step per cycle, WIDTH+1 cycles from start to done.
// Optional macro BOOTH_ABORT_EN adds an abort input that cancels an operation in ITER or FIN.
module booth_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef BOOTH_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Y,
  output logic [1:0]         o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_q;
  logic               r_qm1;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_y;

  logic               w_abort;
  logic [WIDTH:0]     w_msext;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_acc_n;
  logic [WIDTH-1:0]   w_q_n;

`ifdef BOOTH_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Booth step: add/subtract the sign-extended multiplicand, then shift {acc,Q,q_m1} right arithmetically.
  assign w_msext = {r_m[WIDTH-1], r_m};
  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_msext;
      2'b10:   w_sum = r_acc - w_msext;
      default: w_sum = r_acc;
    endcase
  end
  assign w_acc_n = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ITER;
      S_ITER: begin
        if (w_abort)             w_next = S_IDLE;
        else if (r_cnt == CW'(1)) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The product is presented during FIN itself so Y is valid in the same cycle as done.
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FIN) && !w_abort;
  assign Y           = done ? {r_acc[WIDTH-1:0], r_q} : r_y;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_cnt   <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m   <= A;
            r_acc <= '0;
            r_q   <= B;
            r_qm1 <= 1'b0;
            r_cnt <= CW'(WIDTH);
          end
        end
        S_ITER: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIN: begin
          if (done) r_y <= {r_acc[WIDTH-1:0], r_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_sequencer.md
BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal 4..16).
REQ-002 The block SHALL have this port: clk  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have this port: rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have this port: start  input  1  request to begin a multiplication.
REQ-005 The block SHALL have this port: A  input  WIDTH  signed two's-complement multiplicand.
REQ-006 The block SHALL have this port: B  input  WIDTH  signed two's-complement multiplier.
REQ-007 The block SHALL have this port: busy  output  1  high while an operation is in progress.
REQ-008 The block SHALL have this port: done  output  1  one-cycle pulse when Y becomes valid.
REQ-009 The block SHALL have this port: Y  output  2*WIDTH  signed product A*B.
REQ-010 The block SHALL have this port when BOOTH_ABORT_EN is defined: abort  input  1  cancel the current operation.

Function
REQ-011 The block SHALL implement a radix-2 Booth sequencer with states IDLE, ITER and FIN.
REQ-012 In IDLE with start=1, the block SHALL make the following captures on that edge:
- M <= A
- acc <= 0 (WIDTH+1 bits, sign-extended)
- Q <= B
- q_m1 <= 0
- cnt <= WIDTH
- next state ITER
REQ-013 In IDLE, start=0 SHALL leave the state unchanged.
REQ-014 Each ITER cycle SHALL examine {Q[0],q_m1} and update acc as follows:
- 01: acc += sext(M)
- 10: acc -= sext(M)
- 00 or 11: no change
REQ-015 After that update, the same ITER cycle SHALL arithmetic-right-shift {acc,Q,q_m1} by one and decrement cnt.
REQ-016 When cnt reaches 1 in ITER, the next state SHALL be FIN.
REQ-017 In FIN, the block SHALL load Y <= {acc[WIDTH-1:0],Q}, assert done for exactly one cycle, and return to IDLE next cycle.
REQ-018 The latency from the start-sampling edge to done high SHALL be WIDTH+1 cycles (9 for WIDTH=8).
REQ-019 busy SHALL be 1 in ITER and FIN and 0 in IDLE.
REQ-020 A new start SHALL be accepted in the cycle immediately after FIN.
REQ-021 start while busy=1 SHALL be ignored, including in FIN, with no queuing.
REQ-022 A and B SHALL be sampled only at acceptance; later changes SHALL not affect the result.
REQ-023 Y SHALL hold its last value until the next FIN; it SHALL not change in IDLE or ITER.
REQ-024 The acc width of WIDTH+1 SHALL make the product of two most-negative operands exact: (-2^(WIDTH-1))^2 without overflow.
REQ-025 Every product SHALL be exact in 2*WIDTH bits, with no saturation and no wrap.

Reset
REQ-026 When rst=1, the block SHALL immediately, independent of clk, set state=IDLE, busy=0, done=0, Y=0, acc=0, Q=0, q_m1=0, cnt=0 and M=0.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no done pulse and leave Y=0.
REQ-028 In the first edge after rst deasserts, the block SHALL accept start=1 normally.

Configuration
REQ-029 With macro BOOTH_ABORT_EN defined, the abort port SHALL exist with this behaviour:
- abort=1 in ITER or FIN: next state IDLE, done not pulsed, Y keeps its previous value.
- abort has priority over FIN.
- abort in IDLE has no effect; abort and start in the same IDLE cycle means start wins.
REQ-030 With BOOTH_ABORT_EN undefined, the abort port and its logic SHALL be absent and behaviour SHALL be exactly REQ-011..REQ-028.

Verification
REQ-031 The bench SHALL check this scenario: A=3, B=5, start pulse at cycle 0 -> busy high cycles 1-9, done high at cycle 9 only, Y=0x000F.
REQ-032 The bench SHALL check this scenario: A=-128, B=-128 -> Y=0x4000 (16384); A=-128, B=127 -> Y=0xC080 (-16256).
REQ-033 The bench SHALL check this scenario: A=-1, B=127, then change A and B to 0 on the cycle after start -> Y=0xFF81 (-127).
REQ-034 The bench SHALL check this scenario: start with A=7, B=6, then start=1 held with A=2, B=2 during busy, including the FIN cycle -> exactly the following:
- one done with Y=0x002A
- a second operation begins the cycle after FIN, since start is still high
- its result is Y=0x0004
REQ-035 The bench SHALL check this scenario: rst=1 asserted at cycle 4 of an operation -> busy, done and Y go to 0 immediately, no done pulse, then A=2, B=-3 gives Y=0xFFFA.
REQ-036 The bench SHALL check this scenario with BOOTH_ABORT_EN defined: prior Y=0x002A, new start with A=5, B=5, abort at cycle 3 -> busy=0 at cycle 4, no done, Y stays 0x002A.
